// File: rtl/cpu_bus_responder_pkg.sv
// cpu_bus_responder_pkg
//   Shared definitions for the cache-side CPU bus responder.
//   Holds the bus widths, the C1 command encoding, the FSM state encoding,
//   and small command-decode helpers.
//   No ports. The optional C1_PROTO_CHECK_EN feature needs nothing from here.
package cpu_bus_responder_pkg;

  localparam int ADDR1_BUS_SIZE = 15;
  localparam int DATA1_BUS_SIZE = 16;
  localparam int CTR1_BUS_SIZE  = 3;
  localparam int OFFSET_SIZE    = 4;

  localparam int CORE_ADDR_SIZE = ADDR1_BUS_SIZE + OFFSET_SIZE;
  localparam int CORE_DATA_SIZE = 2 * DATA1_BUS_SIZE;

  typedef logic [CTR1_BUS_SIZE-1:0] c1_cmd_t;

  localparam c1_cmd_t C1_NOP             = 3'd0;
  localparam c1_cmd_t C1_READ8           = 3'd1;
  localparam c1_cmd_t C1_READ16          = 3'd2;
  localparam c1_cmd_t C1_READ32          = 3'd3;
  localparam c1_cmd_t C1_INVALIDATE_LINE = 3'd4;
  localparam c1_cmd_t C1_WRITE8          = 3'd5;
  localparam c1_cmd_t C1_WRITE16         = 3'd6;
  localparam c1_cmd_t C1_WRITE32         = 3'd7;
  // RESPONSE shares the WRITE32 code; only the responder ever drives it.
  localparam c1_cmd_t C1_RESPONSE        = 3'd7;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_ADDR2     = 3'd1;
  localparam state_t S_TURN      = 3'd2;
  localparam state_t S_CORE_REQ  = 3'd3;
  localparam state_t S_WAIT_RESP = 3'd4;
  localparam state_t S_RESP1     = 3'd5;
  localparam state_t S_RESP2     = 3'd6;

  function automatic logic cmd_is_write(input c1_cmd_t cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  function automatic logic cmd_is_read(input c1_cmd_t cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

  // Number of D1 words the command moves (1 or 2).
  function automatic logic [1:0] cmd_words(input c1_cmd_t cmd);
    return ((cmd == C1_READ32) || (cmd == C1_WRITE32)) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// cpu_bus_responder_if
//   Valid/ready request channel plus response strobe between the CPU bus
//   responder and the cache core.
//   master : responder side (issues requests, receives responses)
//   slave  : cache core side
//   Signals:
//     core_req_valid  request pending (master -> slave)
//     core_req_ready  core accepts request (slave -> master)
//     core_req_cmd    C1 command of the request
//     core_req_addr   {tick-1 A1, tick-2 offset}
//     core_req_wdata  write data, low half was first on D1
//     core_resp_valid core finished, rdata valid this cycle
//     core_resp_rdata read data
interface cpu_bus_responder_if;
  import cpu_bus_responder_pkg::*;

  logic                      core_req_valid;
  logic                      core_req_ready;
  c1_cmd_t                   core_req_cmd;
  logic [CORE_ADDR_SIZE-1:0] core_req_addr;
  logic [CORE_DATA_SIZE-1:0] core_req_wdata;
  logic                      core_resp_valid;
  logic [CORE_DATA_SIZE-1:0] core_resp_rdata;

  modport master (
    output core_req_valid, core_req_cmd, core_req_addr, core_req_wdata,
    input  core_req_ready, core_resp_valid, core_resp_rdata
  );

  modport slave (
    input  core_req_valid, core_req_cmd, core_req_addr, core_req_wdata,
    output core_req_ready, core_resp_valid, core_resp_rdata
  );

endinterface

// File: rtl/cpu_bus_responder_bus_tristate_driver.sv
// bus_tristate_driver
//   Drives a value onto a shared inout bus when enabled, otherwise releases
//   it to high impedance.
//   Ports:
//     en   drive enable
//     val  value to drive
//     bus  shared inout bus
module bus_tristate_driver #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] val,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = en ? val : {WIDTH{1'bz}};

endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Cache-side endpoint of the CPU bus (C1/A1/D1). Decodes the two-tick
//   command/address/data sequence, passes one request to the cache core,
//   holds C1=NOP while the core works, then returns RESPONSE plus read data
//   and releases the bus.
//   Ports:
//     CLK        clock, everything on the rising edge
//     RESET      synchronous active-low reset
//     A1         CPU address bus
//     D1         shared data bus (inout)
//     C1         shared command bus (inout)
//     core       request/response channel to the cache core (master side)
//     busy       high in every state except IDLE
//     proto_err  sticky tick-2 command mismatch flag (C1_PROTO_CHECK_EN only)
//   Build option:
//     C1_PROTO_CHECK_EN  check that C1 on tick 2 repeats the tick-1 command;
//                        on mismatch flag proto_err and abandon the request.
//
//   state     | meaning
//   IDLE      | bus released, waiting for a non-NOP command on C1
//   ADDR2     | tick 2: offset (and upper write word) on A1/D1
//   TURN      | one dead cycle while the CPU releases C1
//   CORE_REQ  | C1=NOP, request presented to the core until accepted
//   WAIT_RESP | C1=NOP, waiting for the core to finish
//   RESP1     | C1=RESPONSE, first (or only) data word
//   RESP2     | C1=RESPONSE, upper word of READ32
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR1_BUS_SIZE-1:0] A1,
  inout  wire  [DATA1_BUS_SIZE-1:0] D1,
  inout  wire  [CTR1_BUS_SIZE-1:0]  C1,
  cpu_bus_responder_if.master       core,
  output logic                      busy
`ifdef C1_PROTO_CHECK_EN
  ,
  output logic                      proto_err
`endif
);

  state_t                    state_q;
  c1_cmd_t                   cmd_q;
  logic [CORE_ADDR_SIZE-1:0] addr_q;
  logic [CORE_DATA_SIZE-1:0] wdata_q;
  logic [CORE_DATA_SIZE-1:0] rdata_q;

  logic                      c1_oe;
  c1_cmd_t                   c1_out;
  logic                      d1_oe;
  logic [DATA1_BUS_SIZE-1:0] d1_out;
  logic                      c1_known;

  // A floating or half-driven C1 must never start a transaction.
  assign c1_known = !$isunknown(C1);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cmd_q   <= C1_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef C1_PROTO_CHECK_EN
      proto_err <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (c1_known && (C1 != C1_NOP)) begin
            cmd_q   <= C1;
            addr_q  <= {A1, {OFFSET_SIZE{1'b0}}};
            wdata_q <= cmd_is_write(C1) ? {{DATA1_BUS_SIZE{1'b0}}, D1} : '0;
            state_q <= S_ADDR2;
          end
        end
        S_ADDR2: begin
`ifdef C1_PROTO_CHECK_EN
          if (!(c1_known && (C1 == cmd_q))) begin
            proto_err <= 1'b1;
            state_q   <= S_IDLE;
          end else
`endif
          begin
            addr_q[OFFSET_SIZE-1:0] <= A1[OFFSET_SIZE-1:0];
            if (cmd_is_write(cmd_q)) begin
              wdata_q[CORE_DATA_SIZE-1:DATA1_BUS_SIZE] <=
                (cmd_words(cmd_q) == 2'd2) ? D1 : '0;
            end
            state_q <= S_TURN;
          end
        end
        S_TURN: state_q <= S_CORE_REQ;
        S_CORE_REQ: begin
          if (core.core_req_ready) state_q <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          if (core.core_resp_valid) begin
            rdata_q <= core.core_resp_rdata;
            state_q <= S_RESP1;
          end
        end
        S_RESP1: begin
          if (cmd_is_read(cmd_q) && (cmd_words(cmd_q) == 2'd2)) state_q <= S_RESP2;
          else                                                  state_q <= S_IDLE;
        end
        S_RESP2: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus ownership follows the state directly, so leaving the owning states
  // releases C1/D1 on the same edge that enters IDLE.
  assign c1_oe  = (state_q == S_CORE_REQ) || (state_q == S_WAIT_RESP) ||
                  (state_q == S_RESP1)    || (state_q == S_RESP2);
  assign c1_out = ((state_q == S_RESP1) || (state_q == S_RESP2)) ? C1_RESPONSE : C1_NOP;

  assign d1_oe  = ((state_q == S_RESP1) && cmd_is_read(cmd_q)) || (state_q == S_RESP2);

  always_comb begin
    d1_out = '0;
    if (state_q == S_RESP2) begin
      d1_out = rdata_q[CORE_DATA_SIZE-1:DATA1_BUS_SIZE];
    end else if (cmd_q == C1_READ8) begin
      d1_out = {{(DATA1_BUS_SIZE-8){1'b0}}, rdata_q[7:0]};
    end else begin
      d1_out = rdata_q[DATA1_BUS_SIZE-1:0];
    end
  end

  assign core.core_req_valid = (state_q == S_CORE_REQ);
  assign core.core_req_cmd   = cmd_q;
  assign core.core_req_addr  = addr_q;
  assign core.core_req_wdata = wdata_q;

  assign busy = (state_q != S_IDLE);

  bus_tristate_driver #(.WIDTH(CTR1_BUS_SIZE)) c1_drv (
    .en  (c1_oe),
    .val (c1_out),
    .bus (C1)
  );

  bus_tristate_driver #(.WIDTH(DATA1_BUS_SIZE)) d1_drv (
    .en  (d1_oe),
    .val (d1_out),
    .bus (D1)
  );

endmodule

// File: tb/tb_cpu_bus_responder.sv
`timescale 1ns/1ps
module tb_cpu_bus_responder;
  import cpu_bus_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] a1 = '0;
  logic        cpu_c1_oe = 1'b0;
  logic [2:0]  cpu_c1 = '0;
  logic        cpu_d1_oe = 1'b0;
  logic [15:0] cpu_d1 = '0;
  wire  [2:0]  C1;
  wire  [15:0] D1;
  assign C1 = cpu_c1_oe ? cpu_c1 : 3'bzzz;
  assign D1 = cpu_d1_oe ? cpu_d1 : {16{1'bz}};

  logic        core_ready = 1'b0;
  logic        core_resp_valid = 1'b0;
  logic [31:0] core_rdata = '0;
  logic        busy;
`ifdef C1_PROTO_CHECK_EN
  logic        proto_err;
`endif

  cpu_bus_responder_if ifc ();
  assign ifc.core_req_ready  = core_ready;
  assign ifc.core_resp_valid = core_resp_valid;
  assign ifc.core_resp_rdata = core_rdata;

  cpu_bus_responder dut (
    .CLK   (clk),
    .RESET (rst_n),
    .A1    (a1),
    .D1    (D1),
    .C1    (C1),
    .core  (ifc),
    .busy  (busy)
`ifdef C1_PROTO_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic        chk_w;
  } req_t;
  typedef struct {
    logic        drv;
    logic [15:0] d1;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int total = 0;
  int bad = 0;
  int accept_cnt = 0;
  int ready_delay = 0;
  int resp_delay = 1;
  int resp_cnt = 0;
  int valid_cycles = 0;
  logic [31:0] next_rdata = '0;

  logic [3:0]  tr_c [16];
  logic [16:0] tr_d [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [2:0] cmd, input logic [18:0] addr,
                          input logic [31:0] wdata, input logic chk_w);
    req_t r;
    r.cmd = cmd; r.addr = addr; r.wdata = wdata; r.chk_w = chk_w;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic drv, input logic [15:0] d);
    rsp_t r;
    r.drv = drv; r.d1 = d;
    exp_rsp_q.push_back(r);
  endtask

  // Cache core model: ready after ready_delay cycles of valid, response
  // resp_delay cycles after acceptance. Pending responses survive reset.
  initial begin
    forever begin
      @(negedge clk);
      core_resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          core_resp_valid = 1'b1;
          core_rdata = next_rdata;
        end
      end
      if (rst_n && ifc.core_req_valid) begin
        if (valid_cycles >= ready_delay) begin
          core_ready = 1'b1;
          resp_cnt = resp_delay;
        end else begin
          core_ready = 1'b0;
        end
        valid_cycles++;
      end else begin
        core_ready = 1'b0;
        valid_cycles = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    req_t e;
    rsp_t r;
    req_t held;
    logic pend;
    logic acc_prev;
    pend = 1'b0;
    acc_prev = 1'b0;
    held.cmd = '0; held.addr = '0; held.wdata = '0; held.chk_w = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (acc_prev) chk("valid_drop", ifc.core_req_valid, 0);
        if (pend && ifc.core_req_valid) begin
          chk("hold_cmd", ifc.core_req_cmd, held.cmd);
          chk("hold_addr", ifc.core_req_addr, held.addr);
          chk("hold_wdata", ifc.core_req_wdata, held.wdata);
        end
        if (ifc.core_req_valid && core_ready) begin
          accept_cnt++;
          if (exp_req_q.size() == 0) begin
            chk("req_unexpected", 1, 0);
          end else begin
            e = exp_req_q.pop_front();
            chk("req_cmd", ifc.core_req_cmd, e.cmd);
            chk("req_addr", ifc.core_req_addr, e.addr);
            if (e.chk_w) chk("req_wdata", ifc.core_req_wdata, e.wdata);
          end
        end
        acc_prev = ifc.core_req_valid && core_ready;
        pend = ifc.core_req_valid && !core_ready;
        held.cmd = ifc.core_req_cmd;
        held.addr = ifc.core_req_addr;
        held.wdata = ifc.core_req_wdata;
        if (dut.c1_oe && (C1 == C1_RESPONSE)) begin
          if (exp_rsp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            r = exp_rsp_q.pop_front();
            chk("rsp_d1_drv", dut.d1_oe, r.drv);
            if (r.drv) chk("rsp_d1", D1, r.d1);
          end
        end
      end else begin
        acc_prev = 1'b0;
        pend = 1'b0;
      end
    end
  end

  task automatic sample(input int i);
    tr_c[i] = dut.c1_oe ? {1'b0, C1} : 4'h8;
    tr_d[i] = dut.d1_oe ? {1'b0, D1} : 17'h10000;
  endtask

  // Two-tick CPU command; traces responder bus ownership from tick 2 on
  // for n cycles (index 0 = tick 2).
  task automatic cpu_txn(input logic [2:0] t1, input logic [2:0] t2,
                         input logic [14:0] a_hi, input logic [3:0] off,
                         input logic d_en, input logic [15:0] dv1,
                         input logic [15:0] dv2, input int n);
    @(negedge clk);
    cpu_c1_oe = 1'b1; cpu_c1 = t1; a1 = a_hi; cpu_d1_oe = d_en; cpu_d1 = dv1;
    @(negedge clk);
    sample(0);
    cpu_c1 = t2; a1 = {11'b0, off}; cpu_d1 = dv2;
    @(negedge clk);
    sample(1);
    cpu_c1_oe = 1'b0; cpu_d1_oe = 1'b0; a1 = '0; cpu_d1 = '0;
    for (int i = 2; i < n; i++) begin
      @(negedge clk);
      sample(i);
    end
  endtask

  // exp holds one nibble per cycle, first cycle leftmost; 8 means released.
  task automatic chk_c1_trace(input string name, input logic [35:0] exp, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_c1_cyc%0d", name, i), tr_c[i], exp[4*(8-i) +: 4]);
  endtask

  task automatic chk_d1_never(input string name, input int n);
    int drv;
    drv = 0;
    for (int i = 0; i < n; i++) if (tr_d[i] != 17'h10000) drv++;
    chk({name, "_d1_driven_cycles"}, drv, 0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_req_q.size() != 0 || exp_rsp_q.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_complete"}, (k < 60), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int busy_cnt;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ifc.core_req_valid, 0);
    chk("rst_cmd", ifc.core_req_cmd, 0);
    chk("rst_addr", ifc.core_req_addr, 0);
    chk("rst_wdata", ifc.core_req_wdata, 0);
    chk("rst_c1_oe", dut.c1_oe, 0);
    chk("rst_d1_oe", dut.d1_oe, 0);
`ifdef C1_PROTO_CHECK_EN
    chk("rst_proto_err", proto_err, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // INVALIDATE_LINE, minimum latency
    next_rdata = 32'hFFFF_FFFF;
    push_req(C1_INVALIDATE_LINE, 19'h00012, 32'h0, 1'b0);
    push_rsp(1'b0, 16'h0);
    cpu_txn(C1_INVALIDATE_LINE, C1_INVALIDATE_LINE, 15'h0001, 4'h2, 1'b0, 16'h0, 16'h0, 9);
    chk_c1_trace("inv", 36'h880078888, 9);
    chk_d1_never("inv", 9);
    wait_idle("inv");

    // READ32
    next_rdata = 32'hDEAD_BEEF;
    push_req(C1_READ32, 19'h01AB5, 32'h0, 1'b0);
    push_rsp(1'b1, 16'hBEEF);
    push_rsp(1'b1, 16'hDEAD);
    cpu_txn(C1_READ32, C1_READ32, 15'h01AB, 4'h5, 1'b0, 16'h0, 16'h0, 9);
    chk_c1_trace("rd32", 36'h880077888, 9);
    chk("rd32_d1_w0", tr_d[4], 17'h0BEEF);
    chk("rd32_d1_w1", tr_d[5], 17'h0DEAD);
    chk("rd32_d1_release", tr_d[6], 17'h10000);
    wait_idle("rd32");

    // WRITE32
    push_req(C1_WRITE32, 19'h00423, 32'hABCD_1234, 1'b1);
    push_rsp(1'b0, 16'h0);
    cpu_txn(C1_WRITE32, C1_WRITE32, 15'h0042, 4'h3, 1'b1, 16'h1234, 16'hABCD, 9);
    chk_c1_trace("wr32", 36'h880078888, 9);
    chk_d1_never("wr32", 9);
    wait_idle("wr32");

    // WRITE16: tick-2 data must not reach the upper half
    push_req(C1_WRITE16, 19'h12340, 32'h0000_7788, 1'b1);
    push_rsp(1'b0, 16'h0);
    cpu_txn(C1_WRITE16, C1_WRITE16, 15'h1234, 4'h0, 1'b1, 16'h7788, 16'hFFFF, 9);
    chk_d1_never("wr16", 9);
    wait_idle("wr16");

    // READ16 with ready held low for 3 cycles, all-ones address
    ready_delay = 3;
    next_rdata = 32'h7777_5A5A;
    push_req(C1_READ16, 19'h7FFFF, 32'h0, 1'b0);
    push_rsp(1'b1, 16'h5A5A);
    acc0 = accept_cnt;
    cpu_txn(C1_READ16, C1_READ16, 15'h7FFF, 4'hF, 1'b0, 16'h0, 16'h0, 9);
    chk_c1_trace("hold", 36'h880000078, 9);
    wait_idle("hold");
    chk("hold_accepts", accept_cnt - acc0, 1);
    ready_delay = 0;

    // Reset while waiting for the core; stale response must be ignored
    resp_delay = 6;
    next_rdata = 32'h0000_1111;
    push_req(C1_READ8, 19'h01000, 32'h0, 1'b0);
    cpu_txn(C1_READ8, C1_READ8, 15'h0100, 4'h0, 1'b0, 16'h0, 16'h0, 4);
    chk("abort_wait_nop", tr_c[3], 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_c1_oe", dut.c1_oe, 0);
    chk("abort_d1_oe", dut.d1_oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", ifc.core_req_addr, 0);
    chk("abort_cmd", ifc.core_req_cmd, 0);
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || dut.c1_oe) busy_cnt++;
    end
    chk("abort_stale_resp", busy_cnt, 0);
    resp_delay = 1;
    next_rdata = 32'hAAAA_55C3;
    push_req(C1_READ8, 19'h00021, 32'h0, 1'b0);
    push_rsp(1'b1, 16'h00C3);
    cpu_txn(C1_READ8, C1_READ8, 15'h0002, 4'h1, 1'b0, 16'h0, 16'h0, 9);
    chk_c1_trace("rd8", 36'h880078888, 9);
    wait_idle("rd8");

`ifdef C1_PROTO_CHECK_EN
    // Tick-2 command mismatch
    acc0 = accept_cnt;
    cpu_txn(C1_READ16, C1_WRITE8, 15'h0003, 4'h0, 1'b0, 16'h0, 16'h0, 6);
    chk("proto_err_set", proto_err, 1);
    chk_c1_trace("proto", 36'h888888888, 6);
    chk("proto_no_accept", accept_cnt - acc0, 0);
    chk("proto_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("proto_err_sticky", proto_err, 1);
`else
    // Tick-2 command is not checked in this build
    next_rdata = 32'h0000_4321;
    push_req(C1_READ16, 19'h00030, 32'h0, 1'b0);
    push_rsp(1'b1, 16'h4321);
    cpu_txn(C1_READ16, C1_NOP, 15'h0003, 4'h0, 1'b0, 16'h0, 16'h0, 9);
    chk_c1_trace("nochk", 36'h880078888, 9);
    wait_idle("nochk");
`endif

    repeat (3) @(negedge clk);
    chk("left_req", exp_req_q.size(), 0);
    chk("left_rsp", exp_rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
